rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, ROM word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_req input 1, i_addr input ADDR_WIDTH  instruction-fetch request and address.
REQ-006 SHALL have ports i_gnt output 1, i_rvalid output 1, i_rdata output DATA_WIDTH, i_rready input 1  fetch grant and response handshake.
REQ-007 SHALL have ports d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_rready  data-read port, same widths and directions as fetch port.
REQ-008 SHALL have ports rom_addr output ADDR_WIDTH (registered) and rom_data input DATA_WIDTH  ROM samples rom_addr on rising edge and drives rom_data after that edge.

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, DATA, RESP; one transaction in flight at a time.
REQ-010 In IDLE, SHALL assert exactly one of i_gnt/d_gnt combinationally when the corresponding req is high; gnt SHALL be 0 in all other states.
REQ-011 On an edge with a grant, SHALL load rom_addr with the winner's addr, record the owner, and go to ADDR.
REQ-012 ADDR SHALL last exactly one cycle then go to DATA.
REQ-013 In DATA, SHALL capture rom_data into the owner's rdata register, go to RESP.
REQ-014 In RESP, SHALL hold owner's rvalid high and its rdata stable until the owner's rready is sampled high, then go to IDLE.
REQ-015 Latency: rvalid SHALL rise 3 cycles after the granting edge (grant edge +1 ADDR, +1 DATA, +1 RESP).
REQ-016 rready asserted on the first RESP cycle SHALL complete the transaction in that cycle; next grant earliest on the following cycle.
REQ-017 Non-owner's rvalid SHALL stay 0; its rready SHALL be ignored; its rdata SHALL keep its last captured value.
REQ-018 Requests while not in IDLE SHALL be ignored (no queuing); req changes after grant SHALL not affect the transaction.
REQ-019 Without round-robin, simultaneous i_req and d_req SHALL grant the data port.
REQ-020 rdata registers SHALL retain value after rvalid falls until the same port's next DATA capture.
REQ-021 rom_addr SHALL hold its value outside the grant edge.

Reset
REQ-022 reset SHALL force state IDLE; i_rvalid, d_rvalid, i_gnt, d_gnt = 0; i_rdata, d_rdata, rom_addr = 0; round-robin last-owner = fetch port.
REQ-023 reset during ADDR, DATA or RESP SHALL abort the transaction with no response delivered.
REQ-024 reset high SHALL take priority over any request on the same edge.

Configuration
REQ-025 Macro ROM_ARBITER_ROUND_ROBIN_EN SHALL select contention policy.
REQ-026 With macro defined: simultaneous requests SHALL grant the port not granted last; last-owner updates on every grant; single requests granted regardless.
REQ-027 Without macro: fixed priority per REQ-019; no last-owner state.

Verification
REQ-028 Reset, then i_req=1, i_addr=4 with ROM of rom1 content -> i_gnt=1 same cycle, rom_addr=4 next, i_rvalid=1 with i_rdata=20 three cycles after grant.
REQ-029 i_req and d_req both high, d_addr=8, macro off -> d_gnt=1, d_rdata=53; i_gnt granted only after d_rready handshake completes.
REQ-030 Macro on, both ports requesting continuously -> grants alternate D, I, D, I starting with D after reset.
REQ-031 d_rready held 0 for 5 cycles in RESP -> d_rvalid stays 1, d_rdata stable, no new grant; d_rready=1 -> IDLE next cycle.
REQ-032 reset asserted in DATA state -> next cycle IDLE, all rvalid 0, rdata 0, pending response never delivered.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port (fetch/data) arbiter in front of a synchronous ROM.
// One transaction in flight: grant -> ADDR -> DATA -> RESP -> IDLE.
// Optional macro ROM_ARBITER_ROUND_ROBIN_EN: alternate grants under contention
// (default build: data port wins on contention).
module rom_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_rready,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  d_rready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   owner_d;   // 1: data port owns the transaction, 0: fetch port
  logic   done;      // owner's rready while waiting in RESP

`ifdef ROM_ARBITER_ROUND_ROBIN_EN
  logic   last_d;    // 1: data port was granted last
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and combinational grants; grants only in IDLE and never under reset
  always_comb begin
    state_next = state;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    done       = owner_d ? d_rready : i_rready;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (d_req && i_req) begin
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
            if (last_d) i_gnt = 1'b1;
            else        d_gnt = 1'b1;
`else
            d_gnt = 1'b1;
`endif
          end else if (d_req) begin
            d_gnt = 1'b1;
          end else if (i_req) begin
            i_gnt = 1'b1;
          end
          if (i_req || d_req) state_next = ADDR;
        end
      end
      ADDR:    state_next = DATA;
      DATA:    state_next = RESP;
      RESP:    if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address/owner capture on grant, read data capture in DATA, response handshake in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      owner_d  <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
      last_d   <= 1'b0;
`endif
    end else begin
      if (i_gnt || d_gnt) begin
        rom_addr <= d_gnt ? d_addr : i_addr;
        owner_d  <= d_gnt;
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
        last_d   <= d_gnt;
`endif
      end
      if (state == DATA) begin
        if (owner_d) begin
          d_rdata  <= rom_data;
          d_rvalid <= 1'b1;
        end else begin
          i_rdata  <= rom_data;
          i_rvalid <= 1'b1;
        end
      end
      if (state == RESP && done) begin
        i_rvalid <= 1'b0;
        d_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: table of directed transactions plus
// hand sequences for handshake stall, reset abort and reset priority.
module tb_rom_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, i_rready, d_rready;
  logic [AW-1:0] i_addr, d_addr;
  logic          i_gnt, d_gnt, i_rvalid, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  logic [DW-1:0] rom [16];

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_i_rdata = '0;
  logic [DW-1:0] m_d_rdata = '0;
  logic          m_last_d  = 1'b0;

  typedef struct {
    logic          ir;
    logic          dr;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    int            hold;
    logic          exp_d;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_rready(i_rready),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_rready(d_rready),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  // Synchronous ROM model
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full transaction starting from IDLE at a negedge
  task automatic txn(input logic ir, input logic dr, input logic [AW-1:0] ia,
                     input logic [AW-1:0] da, input int hold, input logic exp_d,
                     input logic [DW-1:0] exp_data);
    i_req = ir; d_req = dr; i_addr = ia; d_addr = da;
    i_rready = 1'b0; d_rready = 1'b0;
    #1;
    check("i_gnt", 32'(i_gnt), 32'(!exp_d));
    check("d_gnt", 32'(d_gnt), 32'(exp_d));
    @(posedge clk);
    m_last_d = exp_d;
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; i_addr = ~ia; d_addr = ~da;
    check("rom_addr", 32'(rom_addr), 32'(exp_d ? da : ia));
    check("gnt_in_addr", 32'({i_gnt, d_gnt}), 32'(0));
    @(negedge clk);
    check("rvalid_in_data", 32'({i_rvalid, d_rvalid}), 32'(0));
    @(negedge clk);
    if (exp_d) m_d_rdata = exp_data; else m_i_rdata = exp_data;
    check("i_rvalid_resp", 32'(i_rvalid), 32'(!exp_d));
    check("d_rvalid_resp", 32'(d_rvalid), 32'(exp_d));
    check("i_rdata_resp", 32'(i_rdata), 32'(m_i_rdata));
    check("d_rdata_resp", 32'(d_rdata), 32'(m_d_rdata));
    for (int k = 0; k < hold; k++) begin
      i_req = 1'b1; d_req = 1'b1;
      if (exp_d) i_rready = 1'b1; else d_rready = 1'b1;
      #1;
      check("gnt_in_resp", 32'({i_gnt, d_gnt}), 32'(0));
      @(negedge clk);
      check("rvalid_hold", 32'(exp_d ? d_rvalid : i_rvalid), 32'(1));
      check("rdata_hold", 32'(exp_d ? d_rdata : i_rdata), 32'(exp_data));
    end
    i_req = 1'b0; d_req = 1'b0;
    i_rready = !exp_d; d_rready = exp_d;
    @(negedge clk);
    i_rready = 1'b0; d_rready = 1'b0;
    check("rvalid_done", 32'({i_rvalid, d_rvalid}), 32'(0));
    check("i_rdata_kept", 32'(i_rdata), 32'(m_i_rdata));
    check("d_rdata_kept", 32'(d_rdata), 32'(m_d_rdata));
  endtask

  initial begin
    rom[0] = 8'h11; rom[1] = 8'h2c; rom[2] = 8'h37; rom[3] = 8'h4e;
    rom[4] = 8'd20; rom[5] = 8'h65; rom[6] = 8'h7a; rom[7] = 8'h81;
    rom[8] = 8'd53; rom[9] = 8'h9f; rom[10] = 8'ha4; rom[11] = 8'hbb;
    rom[12] = 8'hc6; rom[13] = 8'hd9; rom[14] = 8'he0; rom[15] = 8'hff;

    vecs[0] = '{ir: 1'b1, dr: 1'b0, ia: 4'd4,  da: 4'd0, hold: 0, exp_d: 1'b0, exp_data: 8'd20};
    vecs[1] = '{ir: 1'b1, dr: 1'b1, ia: 4'd3,  da: 4'd8, hold: 5, exp_d: 1'b1, exp_data: 8'd53};
    vecs[2] = '{ir: 1'b0, dr: 1'b1, ia: 4'd0,  da: 4'd0, hold: 1, exp_d: 1'b1, exp_data: 8'h11};
    vecs[3] = '{ir: 1'b1, dr: 1'b0, ia: 4'd15, da: 4'd0, hold: 2, exp_d: 1'b0, exp_data: 8'hff};
    vecs[4] = '{ir: 1'b1, dr: 1'b1, ia: 4'd1,  da: 4'd2, hold: 0, exp_d: 1'b1, exp_data: 8'h37};
    vecs[5] = '{ir: 1'b1, dr: 1'b1, ia: 4'd6,  da: 4'd9, hold: 0, exp_d: 1'b1, exp_data: 8'h9f};

    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 4'd5; d_addr = 4'd7;
    i_rready = 1'b0; d_rready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    // Reset state and reset priority over pending requests
    check("reset_gnt", 32'({i_gnt, d_gnt}), 32'(0));
    check("reset_rvalid", 32'({i_rvalid, d_rvalid}), 32'(0));
    check("reset_rdata", 32'({i_rdata, d_rdata}), 32'(0));
    check("reset_rom_addr", 32'(rom_addr), 32'(0));
    i_req = 1'b0; d_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("idle_rom_addr_held", 32'(rom_addr), 32'(0));

    for (int v = 0; v < 6; v++) begin
      logic          ed;
      logic [DW-1:0] edata;
      ed = vecs[v].exp_d;
      edata = vecs[v].exp_data;
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
      if (vecs[v].ir && vecs[v].dr) begin
        ed = !m_last_d;
        edata = rom[ed ? vecs[v].da : vecs[v].ia];
      end
`endif
      txn(vecs[v].ir, vecs[v].dr, vecs[v].ia, vecs[v].da, vecs[v].hold, ed, edata);
    end

    // Contention then fetch granted only after the data handshake completes
    i_req = 1'b1; d_req = 1'b1; i_addr = 4'd4; d_addr = 4'd8;
    #1;
    check("seq_d_gnt", 32'(d_gnt), 32'(!m_last_d || 1'b1));
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
    check("seq_rr_start", 32'(m_last_d), 32'(0));
`endif
    @(negedge clk);
    check("seq_no_gnt_addr", 32'({i_gnt, d_gnt}), 32'(0));
    @(negedge clk); @(negedge clk);
    check("seq_d_rdata", 32'(d_rdata), 32'(53));
    check("seq_i_gnt_wait", 32'(i_gnt), 32'(0));
    d_req = 1'b0; d_rready = 1'b1;
    @(negedge clk);
    d_rready = 1'b0;
    #1;
    check("seq_i_gnt_after", 32'(i_gnt), 32'(1));
    i_req = 1'b0;
    m_d_rdata = 8'd53;
    m_last_d = 1'b1;
    @(negedge clk);

    // Reset while in DATA aborts the transaction
    d_req = 1'b1; d_addr = 4'd8;
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1; d_req = 1'b1;
    @(negedge clk);
    #1;
    check("abort_gnt_under_reset", 32'(d_gnt), 32'(0));
    check("abort_rvalid", 32'({i_rvalid, d_rvalid}), 32'(0));
    check("abort_rdata", 32'({i_rdata, d_rdata}), 32'(0));
    check("abort_rom_addr", 32'(rom_addr), 32'(0));
    reset = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_resp", 32'({i_rvalid, d_rvalid}), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
